br_resolve_unit: RTL

//  Consumes the IF-stage predictions issued from the branch target buffer and checks them against the

---
 rtl/br_resolve_unit_pkg.sv | 42 ++++
 rtl/br_resolve_unit_fifo.sv | 84 ++++++++
 rtl/br_resolve_unit.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/br_resolve_unit_pkg.sv
// Shared branch-resolution types: prediction record, BR opcode and the PHT
// counter step used by the resolve unit.
package br_resolve_unit_pkg;

  localparam logic [3:0] op_br    = 4'b0000;
  localparam logic [1:0] PHT_INIT = 2'b01;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] target;
    logic        taken;
  } br_pred_t;

  typedef enum logic [0:0] {
    UPD_IDLE = 1'b0,
    UPD_PEND = 1'b1
  } upd_state_e;

  // Two-bit saturating step: up on taken, down on not-taken, clamped to 0..3.
  function automatic logic [1:0] pht_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      if (ctr == 2'b11) begin
        nxt = 2'b11;
      end else begin
        nxt = ctr + 2'b01;
      end
    end else begin
      if (ctr == 2'b00) begin
        nxt = 2'b00;
      end else begin
        nxt = ctr - 2'b01;
      end
    end
    return nxt;
  endfunction

  function automatic logic [15:0] fallthrough_pc(input logic [15:0] pc);
    return pc + 16'd2;
  endfunction

endpackage

// File: rtl/br_resolve_unit_fifo.sv
// In-flight prediction queue: circular buffer with head/tail pointers and an
// occupancy count; clear wins over push/pop on the same edge.
module br_pred_fifo
  import br_resolve_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  br_pred_t                 push_data_i,
  input  logic                     pop_i,
  input  logic                     clear_i,
  output br_pred_t                 head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  br_pred_t        mem_q [DEPTH];
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push_s;
  logic            do_pop_s;

  assign do_push_s = push_i && (count_q != FULL_CNT) && !clear_i;
  assign do_pop_s  = pop_i && (count_q != {CW{1'b0}}) && !clear_i;

  assign head_o  = mem_q[head_q];
  assign count_o = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear_i) begin
      head_d  = {AW{1'b0}};
      tail_d  = {AW{1'b0}};
      count_d = {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        tail_d = tail_q + AW'(1);
      end else begin
        tail_d = tail_q;
      end
      if (do_pop_s) begin
        head_d = head_q + AW'(1);
      end else begin
        head_d = head_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= {AW{1'b0}};
      tail_q  <= {AW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push_s) begin
      mem_q[tail_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/br_resolve_unit.sv
// Branch resolve unit: checks IF predictions against WB outcomes, raises a
// registered flush/redirect, feeds BTB updates and maintains the 2-bit PHT.
module br_resolve_unit
  import br_resolve_unit_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int PHT_LINES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pred_valid_i,
  input  logic [15:0] pred_pc_i,
  input  logic [15:0] pred_target_i,
  input  logic        pred_taken_i,
  output logic        pred_ready_o,
  input  logic        res_valid_i,
  input  logic [15:0] res_pc_i,
  input  logic        res_taken_i,
  input  logic [15:0] res_target_i,
  output logic        flush_o,
  output logic [15:0] redirect_pc_o,
  output logic        upd_valid_o,
  output logic [15:0] upd_pc_o,
  output logic [15:0] upd_target_o,
  input  logic        upd_ready_i,
  input  logic [15:0] pht_pc_i,
  output logic        pht_taken_o,
  output logic [15:0] mispredicts_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = {1'b1, {(CW-1){1'b0}}};

  br_pred_t      push_data_s;
  br_pred_t      head_s;
  logic [CW-1:0] count_s;
  logic          hit_s;
  logic          eff_taken_s;
  logic [15:0]   eff_target_s;
  logic          mispredict_s;
  logic          push_s;
  logic          new_upd_s;
  logic [15:0]   redirect_s;
  logic [4:0]    pht_wr_idx_s;
  logic [4:0]    pht_rd_idx_s;
  logic          unused_pht_bits;

  logic [1:0]    pht_q [PHT_LINES];
  logic          flush_q;
  logic [15:0]   redirect_q;
  logic [15:0]   mispredicts_q;
  upd_state_e    state_q, state_d;
  logic [15:0]   upd_pc_q, upd_pc_d;
  logic [15:0]   upd_tgt_q, upd_tgt_d;

  assign push_data_s = '{pc: pred_pc_i, target: pred_target_i, taken: pred_taken_i};
  assign pred_ready_o = (count_s != FULL_CNT);
  // IF is still on the wrong path while flush is high, so its pushes are dropped.
  assign push_s = pred_valid_i && pred_ready_o && !flush_q;

  br_pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_s),
    .push_data_i (push_data_s),
    .pop_i       (hit_s),
    .clear_i     (mispredict_s),
    .head_o      (head_s),
    .count_o     (count_s)
  );

  // An unmatched resolve is treated as an implicit not-taken fall-through prediction.
  always_comb begin
    hit_s        = res_valid_i && (count_s != {CW{1'b0}}) && (head_s.pc == res_pc_i);
    eff_taken_s  = 1'b0;
    eff_target_s = fallthrough_pc(res_pc_i);
    if (hit_s) begin
      eff_taken_s  = head_s.taken;
      eff_target_s = head_s.target;
    end else begin
      eff_taken_s  = 1'b0;
      eff_target_s = fallthrough_pc(res_pc_i);
    end
    mispredict_s = res_valid_i &&
                   ((eff_taken_s != res_taken_i) ||
                    (eff_taken_s && res_taken_i && (eff_target_s != res_target_i)));
    new_upd_s    = mispredict_s && res_taken_i;
    if (res_taken_i) begin
      redirect_s = res_target_i;
    end else begin
      redirect_s = fallthrough_pc(res_pc_i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_q       <= 1'b0;
      redirect_q    <= 16'h0000;
      mispredicts_q <= 16'h0000;
    end else begin
      flush_q <= mispredict_s;
      if (mispredict_s) begin
        redirect_q <= redirect_s;
        if (mispredicts_q != 16'hFFFF) begin
          mispredicts_q <= mispredicts_q + 16'd1;
        end
      end
    end
  end

  assign pht_wr_idx_s    = res_pc_i[5:1];
  assign pht_rd_idx_s    = pht_pc_i[5:1];
  assign unused_pht_bits = ^{pht_pc_i[15:6], pht_pc_i[0]};
  assign pht_taken_o     = pht_q[pht_rd_idx_s][1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PHT_LINES; i++) begin
        pht_q[i] <= PHT_INIT;
      end
    end else if (res_valid_i) begin
      pht_q[pht_wr_idx_s] <= pht_next(pht_q[pht_wr_idx_s], res_taken_i);
    end
  end

  // A newer update overwrites a pending one even if the BTB accepts this cycle.
  always_comb begin
    state_d   = state_q;
    upd_pc_d  = upd_pc_q;
    upd_tgt_d = upd_tgt_q;
    case (state_q)
      UPD_IDLE: begin
        if (new_upd_s) begin
          state_d   = UPD_PEND;
          upd_pc_d  = res_pc_i;
          upd_tgt_d = res_target_i;
        end else begin
          state_d   = UPD_IDLE;
        end
      end
      UPD_PEND: begin
        if (new_upd_s) begin
          state_d   = UPD_PEND;
          upd_pc_d  = res_pc_i;
          upd_tgt_d = res_target_i;
        end else if (upd_ready_i) begin
          state_d   = UPD_IDLE;
        end else begin
          state_d   = UPD_PEND;
        end
      end
      default: begin
        state_d = UPD_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= UPD_IDLE;
      upd_pc_q  <= 16'h0000;
      upd_tgt_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      upd_pc_q  <= upd_pc_d;
      upd_tgt_q <= upd_tgt_d;
    end
  end

  assign flush_o       = flush_q;
  assign redirect_pc_o = redirect_q;
  assign mispredicts_o = mispredicts_q;
  assign upd_valid_o   = (state_q == UPD_PEND);
  assign upd_pc_o      = upd_pc_q;
  assign upd_target_o  = upd_tgt_q;

endmodule
